mem_arbiter: RTL and testbench

- Shares the single processor-side memory port between the fetch stage (instruction reads) and the memory stage (data loads/stores).
- Fixed data-over-fetch priority, one outstanding transaction at a time, per-requester stall outputs.
- A taken branch squashes the response of an in-flight fetch.
- Sits between if_stage/mem_stage and the memory model.

---
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and data access: data-over-fetch priority,
// one outstanding transaction, branch squash of in-flight fetches. Optional macro: MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_rsp_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_stall,
  input  logic              ex_take_branch_out,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              arb_owner
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t state, state_nxt;
  logic   owner_q;
  logic   squash_q;
  logic   store_q;
  logic   fetch_pri;
  logic   win_dm;
  logic   grant;
  logic   rsp_done;

  if (STARVE_LIMIT < 1) begin : g_limit_check
    $error("mem_arbiter: STARVE_LIMIT must be at least 1");
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_q;

  assign fetch_pri = if_req & (starve_q == CNT_W'(STARVE_LIMIT));

  // Counts data grants taken while fetch is waiting; saturates so fetch keeps priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
    end else if (!if_req) begin
      starve_q <= '0;
    end else if (grant) begin
      if (!win_dm) begin
        starve_q <= '0;
      end else if (starve_q != CNT_W'(STARVE_LIMIT)) begin
        starve_q <= starve_q + 1'b1;
      end
    end
  end
`else
  assign fetch_pri = 1'b0;
`endif

  assign win_dm   = dm_req & ~fetch_pri;
  assign grant    = (state == IDLE) & (dm_req | if_req) & mem_req_ready;
  assign rsp_done = (state == WAIT) & mem_rsp_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner_q  <= 1'b0;
      squash_q <= 1'b0;
      store_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner_q <= win_dm;
        store_q <= win_dm & dm_we;
      end
      // A flush in the response cycle is handled by the combinational suppress, so squash just clears.
      if (rsp_done) begin
        squash_q <= 1'b0;
      end else if (ex_take_branch_out &
                   (((state == WAIT) & ~owner_q) | (grant & ~win_dm))) begin
        squash_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = WAIT;
      WAIT:    if (mem_rsp_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Everything is combinational from state and inputs, so reset gates all outputs to 0.
  always_comb begin
    mem_req_valid = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    if_rsp_valid  = 1'b0;
    if_rsp_data   = '0;
    dm_rsp_valid  = 1'b0;
    dm_rdata      = '0;
    if_stall      = 1'b0;
    dm_stall      = 1'b0;
    arb_owner     = 1'b0;
    if (!rst) begin
      arb_owner = owner_q;
      if (state == IDLE) begin
        mem_req_valid = dm_req | if_req;
        if (win_dm) begin
          mem_we    = dm_we;
          mem_addr  = dm_addr;
          mem_wdata = dm_wdata;
        end else if (if_req) begin
          mem_addr  = if_addr;
        end
      end
      if (rsp_done) begin
        if (owner_q) begin
          dm_rsp_valid = 1'b1;
          dm_rdata     = store_q ? '0 : mem_rdata;
        end else if (!squash_q && !ex_take_branch_out) begin
          if_rsp_valid = 1'b1;
          if_rsp_data  = mem_rdata;
        end
      end
      if_stall = if_req & ~if_rsp_valid;
      dm_stall = dm_req & ~dm_rsp_valid;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, priority, store, flush, backpressure, reset and grant order.
module tb_mem_arbiter;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_rsp_valid;
  logic [DATA_W-1:0] if_rsp_data;
  logic              if_stall;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_rsp_valid;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_stall;
  logic              ex_take_branch_out;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rdata;
  logic              arb_owner;

  int unsigned tests = 0;
  int unsigned fails = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(2)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rsp_valid(if_rsp_valid),
    .if_rsp_data(if_rsp_data), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rsp_valid(dm_rsp_valid), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .ex_take_branch_out(ex_take_branch_out),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rsp_valid(mem_rsp_valid),
    .mem_rdata(mem_rdata), .arb_owner(arb_owner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic all_zero(input string tag);
    check({tag, " mem_req_valid"}, 64'(mem_req_valid), 64'd0);
    check({tag, " mem_addr"},      64'(mem_addr),      64'd0);
    check({tag, " if_rsp_valid"},  64'(if_rsp_valid),  64'd0);
    check({tag, " dm_rsp_valid"},  64'(dm_rsp_valid),  64'd0);
    check({tag, " if_stall"},      64'(if_stall),      64'd0);
    check({tag, " dm_stall"},      64'(dm_stall),      64'd0);
    check({tag, " arb_owner"},     64'(arb_owner),     64'd0);
  endtask

  logic [5:0] exp_order;

  initial begin
    rst = 1'b1; if_req = 1'b1; if_addr = 32'h10; dm_req = 1'b1; dm_we = 1'b1;
    dm_addr = 32'h200; dm_wdata = 32'h55; ex_take_branch_out = 1'b0;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rdata = 32'h1111;
    #3;
    all_zero("reset");
    tick(); tick();
    rst = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_rsp_valid = 1'b0;
    settle();
    check("idle no req", 64'(mem_req_valid), 64'd0);
    tick();

    // Fetch only
    if_req = 1'b1; if_addr = 32'h10; settle();
    check("f0 valid", 64'(mem_req_valid), 64'd1);
    check("f0 addr",  64'(mem_addr), 64'h10);
    check("f0 we",    64'(mem_we), 64'd0);
    check("f0 stall", 64'(if_stall), 64'd1);
    check("f0 rsp",   64'(if_rsp_valid), 64'd0);
    tick();
    mem_rsp_valid = 1'b1; mem_rdata = 32'hDEADBEEF; settle();
    check("f1 reqv",  64'(mem_req_valid), 64'd0);
    check("f1 rsp",   64'(if_rsp_valid), 64'd1);
    check("f1 data",  64'(if_rsp_data), 64'hDEADBEEF);
    check("f1 stall", 64'(if_stall), 64'd0);
    check("f1 owner", 64'(arb_owner), 64'd0);
    tick();
    if_req = 1'b0; mem_rsp_valid = 1'b0;

    // Simultaneous: data wins, fetch follows
    if_req = 1'b1; if_addr = 32'h80; dm_req = 1'b1; dm_addr = 32'h200; settle();
    check("s0 addr", 64'(mem_addr), 64'h200);
    check("s0 dstall", 64'(dm_stall), 64'd1);
    tick();
    mem_rsp_valid = 1'b1; mem_rdata = 32'h12345678; settle();
    check("s1 owner", 64'(arb_owner), 64'd1);
    check("s1 drsp",  64'(dm_rsp_valid), 64'd1);
    check("s1 ddata", 64'(dm_rdata), 64'h12345678);
    check("s1 irsp",  64'(if_rsp_valid), 64'd0);
    check("s1 istall", 64'(if_stall), 64'd1);
    check("s1 dstall", 64'(dm_stall), 64'd0);
    tick();
    dm_req = 1'b0; mem_rsp_valid = 1'b0; settle();
    check("s2 valid", 64'(mem_req_valid), 64'd1);
    check("s2 addr",  64'(mem_addr), 64'h80);
    tick();
    mem_rsp_valid = 1'b1; mem_rdata = 32'h0BADF00D; settle();
    check("s3 owner", 64'(arb_owner), 64'd0);
    check("s3 irsp",  64'(if_rsp_valid), 64'd1);
    check("s3 idata", 64'(if_rsp_data), 64'h0BADF00D);
    tick();
    if_req = 1'b0; mem_rsp_valid = 1'b0;

    // Store: write fields forwarded, response data forced to 0
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h300; dm_wdata = 32'hCAFE0001; settle();
    check("st0 we",    64'(mem_we), 64'd1);
    check("st0 wdata", 64'(mem_wdata), 64'hCAFE0001);
    tick();
    ex_take_branch_out = 1'b1; mem_rsp_valid = 1'b1; mem_rdata = 32'hFFFF0000; settle();
    check("st1 drsp",  64'(dm_rsp_valid), 64'd1);
    check("st1 rdata", 64'(dm_rdata), 64'd0);
    tick();
    dm_req = 1'b0; dm_we = 1'b0; mem_rsp_valid = 1'b0; ex_take_branch_out = 1'b0;

    // Flush one cycle after acceptance, response three cycles later
    if_req = 1'b1; if_addr = 32'h20; tick();
    ex_take_branch_out = 1'b1; tick();
    ex_take_branch_out = 1'b0; tick();
    tick();
    mem_rsp_valid = 1'b1; mem_rdata = 32'h77777777; settle();
    check("fl rsp squashed", 64'(if_rsp_valid), 64'd0);
    check("fl stall", 64'(if_stall), 64'd1);
    tick();
    mem_rsp_valid = 1'b0; if_addr = 32'h40; settle();
    check("fl new addr", 64'(mem_addr), 64'h40);
    tick();
    mem_rsp_valid = 1'b1; mem_rdata = 32'h40404040; settle();
    check("fl new rsp",  64'(if_rsp_valid), 64'd1);
    check("fl new data", 64'(if_rsp_data), 64'h40404040);
    tick();
    mem_rsp_valid = 1'b0;

    // Flush coincident with the response
    if_addr = 32'h44; tick();
    mem_rsp_valid = 1'b1; ex_take_branch_out = 1'b1; settle();
    check("flc rsp", 64'(if_rsp_valid), 64'd0);
    tick();
    mem_rsp_valid = 1'b0; ex_take_branch_out = 1'b0; if_addr = 32'h48; tick();
    mem_rsp_valid = 1'b1; mem_rdata = 32'h48484848; settle();
    check("flc next rsp", 64'(if_rsp_valid), 64'd1);
    tick();
    if_req = 1'b0; mem_rsp_valid = 1'b0;

    // Backpressure: dm preempts an un-accepted fetch
    mem_req_ready = 1'b0; if_req = 1'b1; if_addr = 32'h30; settle();
    check("bp0 addr", 64'(mem_addr), 64'h30);
    tick(); settle();
    check("bp1 addr", 64'(mem_addr), 64'h30);
    tick();
    dm_req = 1'b1; dm_addr = 32'h310; settle();
    check("bp2 addr", 64'(mem_addr), 64'h310);
    check("bp2 valid", 64'(mem_req_valid), 64'd1);
    tick(); settle();
    check("bp3 addr", 64'(mem_addr), 64'h310);
    tick();
    mem_req_ready = 1'b1; tick(); settle();
    check("bp owner", 64'(arb_owner), 64'd1);
    check("bp wait",  64'(mem_req_valid), 64'd0);
    mem_rsp_valid = 1'b1; mem_rdata = 32'h31031031; settle();
    check("bp drsp", 64'(dm_rsp_valid), 64'd1);
    tick();
    dm_req = 1'b0; mem_rsp_valid = 1'b0; tick();
    mem_rsp_valid = 1'b1; tick();
    if_req = 1'b0; mem_rsp_valid = 1'b0;

    // Reset during a data WAIT, then a stale response
    dm_req = 1'b1; dm_addr = 32'h400; tick();
    rst = 1'b1; if_req = 1'b1; settle();
    all_zero("rstw");
    tick();
    rst = 1'b0; if_req = 1'b0; dm_req = 1'b0; mem_rsp_valid = 1'b1; settle();
    check("stale drsp", 64'(dm_rsp_valid), 64'd0);
    check("stale irsp", 64'(if_rsp_valid), 64'd0);
    tick();
    if_req = 1'b1; if_addr = 32'h50; settle();
    check("stale idle irsp", 64'(if_rsp_valid), 64'd0);
    check("stale idle valid", 64'(mem_req_valid), 64'd1);
    mem_rsp_valid = 1'b0; tick();
    mem_rsp_valid = 1'b1; tick();
    if_req = 1'b0; mem_rsp_valid = 1'b0; tick();

    // Grant order with both requesters held continuously
`ifdef MEM_ARB_STARVE_GUARD_EN
    exp_order = 6'b011011;
`else
    exp_order = 6'b111111;
`endif
    if_req = 1'b1; if_addr = 32'h60; dm_req = 1'b1; dm_addr = 32'h600;
    for (int i = 0; i < 6; i++) begin
      tick();
      mem_rsp_valid = 1'b1; settle();
      check($sformatf("order%0d owner", i), 64'(arb_owner), 64'(exp_order[i]));
      check($sformatf("order%0d drsp", i), 64'(dm_rsp_valid), 64'(exp_order[i]));
      tick();
      mem_rsp_valid = 1'b0;
    end
    if_req = 1'b0; dm_req = 1'b0; tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
